// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle control unit sequencing each instruction through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB), with a ready handshake on memory
// accesses, a saturating wait-cycle timeout and sticky trapping of illegal
// encodings.
// Optional feature macro: OPIMM_EN -- when defined, opcode 0010011 (OP-IMM)
// is a legal instruction retiring through WB; when undefined it traps as an
// illegal opcode.
module ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TW          = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       mem_ready,
  input  logic       zero,
  output logic [2:0] state,
  output logic       fetch,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       branch,
  output logic       alusrc,
  output logic       load,
  output logic       memread,
  output logic       memwrite,
  output logic       regwrite,
  output logic [1:0] aluops,
  output logic [1:0] extnrops,
  output logic [1:0] storeops,
  output logic       trap,
  output logic [1:0] cause,
  output logic       retire
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_ILL  = 2'b01;
  localparam logic [1:0] CAUSE_TMO  = 2'b10;
  localparam logic [1:0] CAUSE_STW  = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_FN  = 2'b10;

  localparam logic [1:0] IMM_I    = 2'b00;
  localparam logic [1:0] IMM_S    = 2'b01;
  localparam logic [1:0] IMM_B    = 2'b10;
  localparam logic [1:0] IMM_NONE = 2'b11;

`ifdef OPIMM_EN
  localparam logic OPIMM_ON = 1'b1;
`else
  localparam logic OPIMM_ON = 1'b0;
`endif

  // A zero MEM_TIMEOUT disables the timeout trap entirely.
  localparam logic          TMO_ON    = (MEM_TIMEOUT > 32'sd0);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(MEM_TIMEOUT);
  localparam logic [TW-1:0] CNT_MAX   = {TW{1'b1}};

  function automatic logic is_load(input logic [6:0] op);
    return (op == OP_LOAD);
  endfunction

  function automatic logic is_store(input logic [6:0] op);
    return (op == OP_STORE);
  endfunction

  function automatic logic is_rtype(input logic [6:0] op);
    return (op == OP_RTYPE);
  endfunction

  function automatic logic is_branch(input logic [6:0] op);
    return (op == OP_BRANCH);
  endfunction

  function automatic logic is_opimm(input logic [6:0] op);
    return OPIMM_ON && (op == OP_OPIMM);
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    return is_load(op) || is_store(op) || is_rtype(op) ||
           is_branch(op) || is_opimm(op);
  endfunction

  // Sequencing state and latched instruction fields
  state_t        state_q, state_d;
  logic [6:0]    op_q, op_d;
  logic [2:0]    f3_q, f3_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [1:0]    cause_q, cause_d;

  // Registered (Moore) outputs
  logic       trap_q, trap_d;
  logic       fetch_q, fetch_d;
  logic       branch_q, branch_d;
  logic       alusrc_q, alusrc_d;
  logic       load_q, load_d;
  logic       memread_q, memread_d;
  logic       memwrite_q, memwrite_d;
  logic       regwrite_q, regwrite_d;
  logic [1:0] aluops_q, aluops_d;
  logic [1:0] extnrops_q, extnrops_d;
  logic [1:0] storeops_q, storeops_d;

  logic tmo_hit;
  logic br_taken;

  // Timeout fires only when the limit is reached and ready is still absent;
  // a ready in that same cycle completes the access instead.
  always_comb begin
    tmo_hit = 1'b0;
    if (TMO_ON && (cnt_q == TMO_LIMIT) && !mem_ready) begin
      tmo_hit = 1'b1;
    end else begin
      tmo_hit = 1'b0;
    end
  end

  // Next state, field latching, cause capture and wait-cycle counter
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    f3_d    = f3_q;
    cause_d = cause_q;
    cnt_d   = {TW{1'b0}};
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (tmo_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TMO;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        op_d = opcode;
        f3_d = funct3;
        if (!is_legal(opcode)) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILL;
        end else if (is_store(opcode) && (funct3 > 3'd2)) begin
          state_d = S_TRAP;
          cause_d = CAUSE_STW;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_load(op_q) || is_store(op_q)) begin
          state_d = S_MEM;
        end else if (is_rtype(op_q) || is_opimm(op_q)) begin
          state_d = S_WB;
        end else if (is_branch(op_q)) begin
          state_d = S_FETCH;
        end else begin
          // Unreachable with a legal latched opcode; fail safe into TRAP.
          state_d = S_TRAP;
          cause_d = CAUSE_ILL;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (is_load(op_q)) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
          end
        end else if (tmo_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TMO;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_IDLE;
        cause_d = CAUSE_NONE;
      end
    endcase

    // The counter only survives while waiting in FETCH/MEM, so any entry
    // into those states starts it from zero; it saturates instead of wrapping.
    if (((state_q == S_FETCH) || (state_q == S_MEM)) && (state_d == state_q)) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + TW'(1'b1);
      end
    end else begin
      cnt_d = {TW{1'b0}};
    end
  end

  // Moore outputs for the state being entered, from the next-cycle fields
  always_comb begin
    trap_d     = 1'b0;
    fetch_d    = 1'b0;
    branch_d   = 1'b0;
    alusrc_d   = 1'b0;
    load_d     = 1'b0;
    memread_d  = 1'b0;
    memwrite_d = 1'b0;
    regwrite_d = 1'b0;
    aluops_d   = ALU_ADD;
    extnrops_d = IMM_I;
    storeops_d = 2'b00;
    case (state_d)
      S_FETCH: begin
        fetch_d = 1'b1;
      end
      S_EXEC: begin
        if (is_load(op_d)) begin
          alusrc_d   = 1'b1;
          aluops_d   = ALU_ADD;
          extnrops_d = IMM_I;
        end else if (is_store(op_d)) begin
          alusrc_d   = 1'b1;
          aluops_d   = ALU_ADD;
          extnrops_d = IMM_S;
        end else if (is_rtype(op_d)) begin
          aluops_d   = ALU_FN;
          extnrops_d = IMM_NONE;
        end else if (is_branch(op_d)) begin
          branch_d   = 1'b1;
          aluops_d   = ALU_SUB;
          extnrops_d = IMM_B;
        end else if (is_opimm(op_d)) begin
          alusrc_d   = 1'b1;
          aluops_d   = ALU_FN;
          extnrops_d = IMM_I;
        end else begin
          aluops_d   = ALU_ADD;
        end
      end
      S_MEM: begin
        if (is_load(op_d)) begin
          memread_d = 1'b1;
          alusrc_d  = 1'b1;
        end else if (is_store(op_d)) begin
          memwrite_d = 1'b1;
          alusrc_d   = 1'b1;
          // funct3 0/1/2 (byte/half/word) maps onto storeops 01/10/11.
          storeops_d = f3_d[1:0] + 2'd1;
        end else begin
          memread_d = 1'b0;
        end
      end
      S_WB: begin
        regwrite_d = 1'b1;
        load_d     = is_load(op_d);
      end
      S_TRAP: begin
        trap_d = 1'b1;
      end
      default: begin
        trap_d = 1'b0;
      end
    endcase
  end

  // Single state register holding FSM state, latched fields and Moore outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= 7'd0;
      f3_q       <= 3'd0;
      cnt_q      <= {TW{1'b0}};
      cause_q    <= CAUSE_NONE;
      trap_q     <= 1'b0;
      fetch_q    <= 1'b0;
      branch_q   <= 1'b0;
      alusrc_q   <= 1'b0;
      load_q     <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      regwrite_q <= 1'b0;
      aluops_q   <= 2'b00;
      extnrops_q <= 2'b00;
      storeops_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      f3_q       <= f3_d;
      cnt_q      <= cnt_d;
      cause_q    <= cause_d;
      trap_q     <= trap_d;
      fetch_q    <= fetch_d;
      branch_q   <= branch_d;
      alusrc_q   <= alusrc_d;
      load_q     <= load_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      regwrite_q <= regwrite_d;
      aluops_q   <= aluops_d;
      extnrops_q <= extnrops_d;
      storeops_q <= storeops_d;
    end
  end

  // Same-cycle handshake outputs: fetch/branch completion and retirement.
  // pc_src follows pc_write in EXEC so it is only 1 when a branch is taken.
  always_comb begin
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_src   = 1'b0;
    retire   = 1'b0;
    br_taken = (state_q == S_EXEC) && is_branch(op_q) && zero;
    case (state_q)
      S_FETCH: begin
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_EXEC: begin
        pc_write = br_taken;
        pc_src   = br_taken;
        retire   = is_branch(op_q);
      end
      S_MEM: begin
        retire = is_store(op_q) && mem_ready;
      end
      S_WB: begin
        retire = 1'b1;
      end
      default: begin
        retire = 1'b0;
      end
    endcase
  end

  assign state    = state_q;
  assign fetch    = fetch_q;
  assign branch   = branch_q;
  assign alusrc   = alusrc_q;
  assign load     = load_q;
  assign memread  = memread_q;
  assign memwrite = memwrite_q;
  assign regwrite = regwrite_q;
  assign aluops   = aluops_q;
  assign extnrops = extnrops_q;
  assign storeops = storeops_q;
  assign trap     = trap_q;
  assign cause    = cause_q;

endmodule

// File: doc/ctrl_fsm.md
# ctrl_fsm

Multi-cycle control unit and successor to the single-cycle combinational decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states. Memory accesses use a ready handshake with a parametrised timeout, and illegal encodings are trapped. It sits between the instruction register / memory interface and the datapath (ALU, immediate extender, register file, PC).

## Interface
Parameters:
- MEM_TIMEOUT, 15: max wait cycles on one memory access before trap; 0 disables the timeout.
- TW, 4: timeout counter width; must satisfy 2^TW > MEM_TIMEOUT.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- opcode  input  7  instruction opcode; sampled only in DECODE
- funct3  input  3  instruction funct3; sampled only in DECODE
- mem_ready  input  1  memory completes the current access this cycle
- zero  input  1  ALU zero flag; used in EXEC of a branch
- state  output  3  current state: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6
- fetch  output  1  instruction read request
- ir_write  output  1  latch instruction register
- pc_write  output  1  update PC
- pc_src  output  1  0 = PC+4, 1 = branch target
- branch, alusrc, load, memread, memwrite, regwrite  output  1 each  datapath controls
- aluops  output  2  00 add (load/store), 01 sub (branch), 10 R-type funct decode
- extnrops  output  2  immediate format: 00 I, 01 S, 10 B, 11 R/none
- storeops  output  2  store width: 01 byte, 10 half, 11 word; 00 when not storing
- trap  output  1  sticky fault flag
- cause  output  2  01 illegal opcode, 10 memory timeout, 11 illegal store funct3
- retire  output  1  one-cycle pulse when an instruction completes

## Operation
- Opcodes: load 0000011, store 0100011, R-type 0110011, branch 1100011 (beq).
- In DECODE, opcode and funct3 are latched into internal registers. All later outputs derive from the state and these latched fields.
- IDLE: all outputs 0. Unconditional move to FETCH.
- FETCH: fetch=1 is held until mem_ready. In the cycle where mem_ready=1, ir_write=1 and pc_write=1 (pc_src=0), and the next state is DECODE.
- DECODE: an unknown opcode goes to TRAP with cause=01. A store with funct3>2 goes to TRAP with cause=11. Otherwise the next state is EXEC.
- EXEC:
  - Load: alusrc=1, aluops=00, extnrops=00; next state MEM.
  - Store: alusrc=1, aluops=00, extnrops=01; next state MEM.
  - R-type: aluops=10, extnrops=11; next state WB.
  - Branch: branch=1, aluops=01, extnrops=10. If zero=1, pc_write=1 and pc_src=1. retire=1; next state FETCH.
- MEM:
  - Load: memread=1, alusrc=1 held.
  - Store: memwrite=1, alusrc=1, storeops=funct3+1 held.
  - On mem_ready, a load goes to WB. A store sets retire=1 and goes to FETCH.
- WB: regwrite=1 and retire=1. load=1 for loads only. Next state FETCH.
- TRAP: all datapath outputs 0. trap=1 and cause stays stable. The block stays in TRAP until reset.
- Timeout counter: cleared on entry to FETCH or MEM. It increments each cycle mem_ready=0 in those states.
  - If the counter equals MEM_TIMEOUT and mem_ready=0, the next state is TRAP with cause=10.
  - mem_ready=1 in that same cycle wins; no trap.
  - The counter saturates and never wraps.
- Asserting reset mid-access abandons the access immediately; no partial retire.

## Timing
- Reset: state=IDLE; every output 0, including trap and cause; latched fields and counter cleared.
- All state changes happen on the rising edge of clk. Outputs are Moore-style, except these, which are combinational in the current cycle: ir_write, pc_write in FETCH, pc_write in EXEC, and retire.
- Cycles from FETCH entry with zero wait states: branch 3, R-type 4, store 4, load 5. Each memory wait cycle adds 1.
- Timeout with MEM_TIMEOUT=N: TRAP is entered at edge N+1 after entering the state, if ready never arrives.

## Configuration
- OPIMM_EN defined: opcode 0010011 (OP-IMM) is legal.
  - EXEC: alusrc=1, aluops=10, extnrops=00; next state WB with regwrite=1, load=0.
  - Total 4 cycles.
- OPIMM_EN undefined: 0010011 traps in DECODE with cause=01.

## Test plan
- Reset, then R-type 0110011 with mem_ready always 1 -> states 0,1,2,3,5,1. regwrite=1 only in WB; retire pulses once.
- Load 0000011 with 3 fetch wait cycles and 2 MEM wait cycles -> fetch high 4 cycles, memread high 3 cycles, load=1 in WB; 10 cycles from FETCH entry to the next FETCH.
- Store funct3=001 -> storeops=10 in MEM. Store funct3=011 -> TRAP with cause=11, trap stays 1 for 100 cycles.
- Branch with zero=1 -> pc_write=1 and pc_src=1 in EXEC. With zero=0 -> pc_write=0 in EXEC; back to FETCH after 3 cycles.
- MEM_TIMEOUT=4 with mem_ready stuck 0 in MEM -> TRAP with cause=10 on the 5th edge. Ready arriving on wait cycle 4 -> no trap.
- OPIMM_EN builds: 0010011 retires through WB with regwrite=1. Non-OPIMM_EN builds: 0010011 traps with cause=01. Reset asserted mid-MEM -> IDLE with all outputs 0 immediately.
